// File: rtl/johnson_pkg.sv
// johnson_pkg: shared constants and code/legality helpers for the Johnson counter.
package johnson_pkg;
    localparam int MAX_W = 64;
    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    // Phase p <= width: p ones from the MSB; p > width: (p-width) zeros from the MSB, rest ones.
    function automatic logic [MAX_W-1:0] code(input int width, input int phase);
        logic [MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_W; i++)
            if (i < width) v[i] = (phase <= width) ? (i >= width - phase) : (i < 2 * width - phase);
        return v;
    endfunction

    // A legal Johnson code has at most one transition between adjacent bits.
    function automatic logic is_legal(input logic [MAX_W-1:0] v, input int width);
        int t;
        t = 0;
        for (int i = 1; i < MAX_W; i++)
            if (i < width && v[i] != v[i-1]) t++;
        return t <= 1;
    endfunction
endpackage

// File: rtl/johnson_phase_decode.sv
// johnson_phase_decode: maps a Johnson code to its binary phase and a legality flag.
module johnson_phase_decode import johnson_pkg::*; #(
    parameter int WIDTH = 4,
    localparam int PHASE_W = clog2(2 * WIDTH)
) (
    input  logic [WIDTH-1:0]   i_cnt,
    output logic [PHASE_W-1:0] o_phase,
    output logic               o_legal
);
    int w_ones;
    assign w_ones  = $countones(i_cnt);
    assign o_phase = PHASE_W'(i_cnt[WIDTH-1] ? w_ones : (w_ones == 0 ? 0 : 2 * WIDTH - w_ones));
    assign o_legal = is_legal(MAX_W'(i_cnt), WIDTH);
endmodule

// File: rtl/johnson_counter_ctrl.sv
// johnson_counter_ctrl: bidirectional Johnson counter with load, wrap strobe and illegal-code recovery.
module johnson_counter_ctrl import johnson_pkg::*; #(
    parameter int WIDTH = 4,
    parameter int RST_PHASE = 0,
    localparam int PHASE_W = clog2(2 * WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_en,
    input  logic               i_dir,
    input  logic               i_load,
    input  logic [PHASE_W-1:0] i_load_phase,
    output logic [WIDTH-1:0]   o_cnt,
    output logic [PHASE_W-1:0] o_phase,
    output logic               o_wrap,
    output logic               o_illegal
);
    localparam int PHASES = 2 * WIDTH;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_next;
    logic r_wrap, r_illegal, w_wrap, w_illegal, w_legal, w_load_ok;
    logic [PHASE_W-1:0] w_phase;

    johnson_phase_decode #(.WIDTH(WIDTH)) u_dec (
        .i_cnt   (r_cnt),
        .o_phase (w_phase),
        .o_legal (w_legal)
    );

    assign w_load_ok = int'(i_load_phase) < PHASES;

    // Priority: load, then illegal-code recovery, then step, else hold.
    always_comb begin
        w_next    = r_cnt;
        w_wrap    = 1'b0;
        w_illegal = 1'b0;
        if (i_load) begin
            w_next    = w_load_ok ? WIDTH'(code(WIDTH, int'(i_load_phase))) : '0;
            w_illegal = !w_load_ok;
        end else if (!w_legal) begin
            w_next    = '0;
            w_illegal = 1'b1;
        end else if (i_en) begin
            w_next = (i_dir == DIR_FWD) ? {~r_cnt[0], r_cnt[WIDTH-1:1]} : {r_cnt[WIDTH-2:0], ~r_cnt[WIDTH-1]};
            w_wrap = (i_dir == DIR_FWD) ? (w_phase == PHASE_W'(PHASES - 1)) : (w_phase == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= WIDTH'(code(WIDTH, RST_PHASE));
            r_wrap    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_cnt     <= w_next;
            r_wrap    <= w_wrap;
            r_illegal <= w_illegal;
        end
    end

    assign o_cnt     = r_cnt;
    assign o_phase   = w_phase;
    assign o_wrap    = r_wrap;
    assign o_illegal = r_illegal;
endmodule
